// File: rtl/collision_pkg.sv
// Shared collision definitions: scan FSM states and default geometry.
// The sprite renderer imports the same size constants so drawing and
// collision agree on the player and tile footprints.
package collision_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  localparam int DEF_NUM_BLK = 16;
  localparam int DEF_X_W     = 10;
  localparam int DEF_Y_W     = 9;
  localparam int DEF_PL_W    = 47;
  localparam int DEF_PL_H    = 41;
  localparam int DEF_BK_W    = 25;
  localparam int DEF_BK_H    = 24;
  localparam int DEF_TOL     = 3;

endpackage

// File: rtl/collision_tile_cmp.sv
// Single-tile, four-side contact comparator (purely combinational).
// Coordinates are zero-extended by two bits so that neither tiles near the
// origin nor sums past the screen edge can wrap and fake a contact.
module collision_tile_cmp
  import collision_pkg::*;
#(
  parameter int X_W  = DEF_X_W,
  parameter int Y_W  = DEF_Y_W,
  parameter int PL_W = DEF_PL_W,
  parameter int PL_H = DEF_PL_H,
  parameter int BK_W = DEF_BK_W,
  parameter int BK_H = DEF_BK_H,
  parameter int TOL  = DEF_TOL
) (
  input  logic [X_W-1:0] px,
  input  logic [Y_W-1:0] py,
  input  logic [X_W-1:0] bx,
  input  logic [Y_W-1:0] by,
  input  logic           en,
  output logic [3:0]     hit   // {left, right, up, down}
);

  localparam int XE = X_W + 2;
  localparam int YE = Y_W + 2;

  logic [XE-1:0] px_e, bx_e, cx, pr;
  logic [YE-1:0] py_e, by_e, pb;
  logic          cx_in, v_ovl, down, up, right, left;

  // Extended-width geometry: centre column, player bottom and right edge.
  always_comb begin
    px_e  = XE'(px);
    bx_e  = XE'(bx);
    py_e  = YE'(py);
    by_e  = YE'(by);
    cx    = px_e + XE'(PL_W / 2);
    pr    = px_e + XE'(PL_W);
    pb    = py_e + YE'(PL_H);
    cx_in = (bx_e <= cx) && (cx <= bx_e + XE'(BK_W));
    down  = cx_in && (by_e <= pb) && (pb <= by_e + YE'(TOL));
    up    = cx_in && (by_e + YE'(BK_H) <= py_e) && (py_e <= by_e + YE'(BK_H + TOL));
    v_ovl = (pb > by_e) && (py_e < by_e + YE'(BK_H));
    right = v_ovl && (bx_e <= pr + XE'(TOL)) && (pr <= bx_e + XE'(TOL));
    left  = v_ovl && (bx_e + XE'(BK_W - TOL) <= px_e) && (px_e <= bx_e + XE'(BK_W + TOL));
    hit   = en ? {left, right, up, down} : 4'b0000;
  end

endmodule

// File: rtl/collision_scan.sv
// Per-frame ground-tile collision scanner.
// A start tick latches the player position, walks the tile table one
// address per cycle, OR-accumulates contact sides and remembers the top of
// the first tile the player lands on. Results publish together with done.
// Tile data returns one cycle after its address, so evaluation trails the
// address by one cycle and a single DRAIN cycle finishes the last tile.
module collision_scan
  import collision_pkg::*;
#(
  parameter int NUM_BLK = DEF_NUM_BLK,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int PL_W    = DEF_PL_W,
  parameter int PL_H    = DEF_PL_H,
  parameter int BK_W    = DEF_BK_W,
  parameter int BK_H    = DEF_BK_H,
  parameter int TOL     = DEF_TOL,
  localparam int IW     = $clog2(NUM_BLK)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [X_W-1:0] x_blue,
  input  logic [Y_W-1:0] y_blue,
  output logic [IW-1:0]  blk_idx,
  input  logic [X_W-1:0] blk_x,
  input  logic [Y_W-1:0] blk_y,
  input  logic           blk_en,
  output logic           busy,
  output logic           done,
  output logic [3:0]     is_Collision,
  output logic           land_valid,
  output logic [Y_W-1:0] land_y,
  output scan_state_t    state_dbg
);

  scan_state_t    state, state_nx;
  logic [X_W-1:0] px_l;
  logic [Y_W-1:0] py_l;
  logic [3:0]     acc_hit, acc_hit_nx, tile_hit;
  logic           acc_lv, acc_lv_nx;
  logic [Y_W-1:0] acc_ly, acc_ly_nx;
  logic           eval;
  logic           last_idx;

  collision_tile_cmp #(
    .X_W (X_W), .Y_W (Y_W), .PL_W(PL_W), .PL_H(PL_H),
    .BK_W(BK_W), .BK_H(BK_H), .TOL (TOL)
  ) u_cmp (
    .px (px_l),
    .py (py_l),
    .bx (blk_x),
    .by (blk_y),
    .en (blk_en),
    .hit(tile_hit)
  );

  // Next state, status outputs and accumulator update for the current tile.
  always_comb begin
    state_nx   = state;
    last_idx   = (blk_idx == IW'(NUM_BLK - 1));
    // Address 0 is on the bus during the first SCAN cycle; its data is not back yet.
    eval       = ((state == ST_SCAN) && (blk_idx != '0)) || (state == ST_DRAIN);
    acc_hit_nx = acc_hit | tile_hit;
    acc_lv_nx  = acc_lv;
    acc_ly_nx  = acc_ly;
    if (!acc_lv && tile_hit[0]) begin
      acc_lv_nx = 1'b1;
      acc_ly_nx = blk_y;
    end
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SCAN;
      ST_SCAN:  if (last_idx) state_nx = ST_DRAIN;
      ST_DRAIN: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    state_dbg = state;
  end

  // State register, position latch, address counter, accumulators, results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      blk_idx      <= '0;
      px_l         <= '0;
      py_l         <= '0;
      acc_hit      <= '0;
      acc_lv       <= 1'b0;
      acc_ly       <= '0;
      is_Collision <= '0;
      land_valid   <= 1'b0;
      land_y       <= '0;
    end else begin
      state <= state_nx;
      if ((state == ST_IDLE) && start) begin
        px_l    <= x_blue;
        py_l    <= y_blue;
        blk_idx <= '0;
        acc_hit <= '0;
        acc_lv  <= 1'b0;
        acc_ly  <= '0;
      end else begin
        if ((state == ST_SCAN) && !last_idx) blk_idx <= blk_idx + IW'(1);
        if (eval) begin
          acc_hit <= acc_hit_nx;
          acc_lv  <= acc_lv_nx;
          acc_ly  <= acc_ly_nx;
        end
      end
      // The last tile is folded in on the way into DONE so results and done coincide.
      if (state == ST_DRAIN) begin
        is_Collision <= acc_hit_nx;
        land_valid   <= acc_lv_nx;
        land_y       <= acc_ly_nx;
      end
    end
  end

endmodule

// File: tb/tb_collision_scan.sv
// Bench for collision_scan: directed landing/bump/wall/edge/protocol cases
// plus randomized frames, checked against a geometric reference model.
module tb_collision_scan;
  import collision_pkg::*;

  localparam int NUM_BLK = 16;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int IW = 4;
  localparam int M_PL_W = 47, M_PL_H = 41, M_BK_W = 25, M_BK_H = 24, M_TOL = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [X_W-1:0] x_blue = '0;
  logic [Y_W-1:0] y_blue = '0;
  logic [IW-1:0]  blk_idx;
  logic [X_W-1:0] blk_x = '0;
  logic [Y_W-1:0] blk_y = '0;
  logic           blk_en = 1'b0;
  logic           busy, done, land_valid;
  logic [3:0]     is_Collision;
  logic [Y_W-1:0] land_y;
  scan_state_t    state_dbg;

  collision_scan #(.NUM_BLK(NUM_BLK), .X_W(X_W), .Y_W(Y_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_blue(x_blue), .y_blue(y_blue),
    .blk_idx(blk_idx), .blk_x(blk_x), .blk_y(blk_y), .blk_en(blk_en),
    .busy(busy), .done(done), .is_Collision(is_Collision),
    .land_valid(land_valid), .land_y(land_y), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // tile table with one-cycle read latency
  int tbx[NUM_BLK];
  int tby[NUM_BLK];
  bit ten[NUM_BLK];
  always @(posedge clk) begin
    blk_x  <= X_W'(tbx[blk_idx]);
    blk_y  <= Y_W'(tby[blk_idx]);
    blk_en <= ten[blk_idx];
  end

  typedef struct packed {
    logic [31:0]    start_cyc;
    logic [3:0]     flags;
    logic           lv;
    logic [Y_W-1:0] ly;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  logic [3:0]     last_f  = '0;
  logic           last_lv = 1'b0;
  logic [Y_W-1:0] last_ly = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // reference model: plain integer geometry over the whole table
  function automatic exp_t model(input int px, input int py);
    exp_t e;
    int cx, bx, by;
    bit d, u, r, l, v, cin;
    e = '0;
    cx = px + M_PL_W / 2;
    for (int i = 0; i < NUM_BLK; i++) begin
      if (!ten[i]) continue;
      bx = tbx[i];
      by = tby[i];
      cin = (cx >= bx) && (cx <= bx + M_BK_W);
      d = cin && (py + M_PL_H >= by) && (py + M_PL_H <= by + M_TOL);
      u = cin && (py >= by + M_BK_H) && (py <= by + M_BK_H + M_TOL);
      v = (py + M_PL_H > by) && (py < by + M_BK_H);
      r = v && (px + M_PL_W >= bx - M_TOL) && (px + M_PL_W <= bx + M_TOL);
      l = v && (px >= bx + M_BK_W - M_TOL) && (px <= bx + M_BK_W + M_TOL);
      e.flags |= {l, r, u, d};
      if (d && !e.lv) begin
        e.lv = 1'b1;
        e.ly = Y_W'(by);
      end
    end
    return e;
  endfunction

  // monitor: every done pulse pops one expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("latency", 32'(cyc), e.start_cyc + NUM_BLK + 2);
        check("is_Collision", 32'(is_Collision), 32'(e.flags));
        check("land_valid", 32'(land_valid), 32'(e.lv));
        check("land_y", 32'(land_y), 32'(e.ly));
        check("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic clear_tiles();
    for (int i = 0; i < NUM_BLK; i++) begin
      tbx[i] = 0; tby[i] = 0; ten[i] = 1'b0;
    end
  endtask

  task automatic set_tile(input int i, input int bx, input int by, input bit en);
    tbx[i] = bx; tby[i] = by; ten[i] = en;
  endtask

  function automatic int clip(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // one frame; perturb moves the player and retries start while busy
  task automatic do_scan(input int px, input int py, input bit perturb);
    exp_t e;
    int budget;
    @(negedge clk);
    x_blue = X_W'(px);
    y_blue = Y_W'(py);
    e = model(px, py);
    e.start_cyc = 32'(cyc);
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(2, 8)) @(negedge clk);
    check("hold_mid_scan", 32'({is_Collision, land_valid, land_y}), 32'({last_f, last_lv, last_ly}));
    if (perturb) begin
      x_blue = X_W'($urandom_range(0, 1023));
      y_blue = Y_W'($urandom_range(0, 511));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 3 * NUM_BLK) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
    last_f = e.flags; last_lv = e.lv; last_ly = e.ly;
    repeat (3) @(negedge clk);
    check("hold_after_done", 32'({is_Collision, land_valid, land_y}), 32'({last_f, last_lv, last_ly}));
  endtask

  task automatic reset_mid_scan();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_outputs", 32'({is_Collision, land_valid, land_y}), 32'd0);
    check("rst_blk_idx", 32'(blk_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NUM_BLK + 6) @(negedge clk);
    check("post_abort_outputs", 32'({is_Collision, land_valid, land_y}), 32'd0);
    last_f = '0; last_lv = 1'b0; last_ly = '0;
  endtask

  task automatic random_frame();
    int px, py, mode;
    px = $urandom_range(0, 1023);
    py = $urandom_range(0, 511);
    for (int i = 0; i < NUM_BLK; i++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        1: set_tile(i, clip(px + 23 - $urandom_range(0, 27), 1023), clip(py + 41 - $urandom_range(0, 4), 511), 1'b1);
        2: set_tile(i, clip(px + 23 - $urandom_range(0, 27), 1023), clip(py - 24 - $urandom_range(0, 4), 511), 1'b1);
        3: set_tile(i, clip(px + 44 + $urandom_range(0, 7), 1023), clip(py - 20 + $urandom_range(0, 60), 511), 1'b1);
        4: set_tile(i, clip(px - 29 + $urandom_range(0, 7), 1023), clip(py - 20 + $urandom_range(0, 60), 511), 1'b1);
        default: set_tile(i, $urandom_range(0, 1023), $urandom_range(0, 511), 1'b1);
      endcase
      if ($urandom_range(0, 5) == 0) ten[i] = 1'b0;
    end
    do_scan(px, py, ($urandom_range(0, 2) == 0));
  endtask

  initial begin
    clear_tiles();
    repeat (2) @(negedge clk);
    check("reset_state", 32'({busy, done, is_Collision, land_valid, land_y, blk_idx}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // landing
    clear_tiles(); set_tile(0, 100, 200, 1'b1);
    do_scan(90, 159, 1'b0);
    check("land_flags", 32'(is_Collision), 32'b0001);
    check("land_y_200", 32'(land_y), 32'd200);
    // head bump
    clear_tiles(); set_tile(3, 100, 100, 1'b1);
    do_scan(90, 125, 1'b0);
    check("bump_flags", 32'({is_Collision, land_valid}), 32'b00100);
    // walls
    clear_tiles(); set_tile(1, 200, 100, 1'b1);
    do_scan(150, 100, 1'b0);
    check("right_wall", 32'(is_Collision), 32'b0100);
    clear_tiles(); set_tile(2, 50, 100, 1'b1);
    do_scan(76, 100, 1'b0);
    check("left_wall", 32'(is_Collision), 32'b1000);
    clear_tiles(); set_tile(1, 200, 100, 1'b1); set_tile(2, 126, 100, 1'b1);
    do_scan(150, 100, 1'b0);
    check("both_walls", 32'(is_Collision), 32'b1100);
    // origin / far-edge tiles must not wrap into hits
    clear_tiles(); set_tile(0, 1, 0, 1'b1); set_tile(1, 1000, 500, 1'b0);
    do_scan(0, 0, 1'b0);
    check("edge_no_wrap", 32'({is_Collision, land_valid}), 32'd0);
    clear_tiles(); set_tile(NUM_BLK - 1, 0, 0, 1'b1);
    do_scan(1023, 511, 1'b0);
    // first down hit wins
    clear_tiles(); set_tile(5, 100, 200, 1'b1); set_tile(2, 100, 198, 1'b1);
    do_scan(90, 159, 1'b0);
    check("land_first_idx", 32'({land_valid, land_y}), 32'({1'b1, 9'd198}));
    // ignored start while busy, then reset mid-scan and recovery
    clear_tiles(); set_tile(0, 100, 200, 1'b1);
    do_scan(90, 159, 1'b1);
    reset_mid_scan();
    do_scan(90, 159, 1'b0);

    for (int n = 0; n < 40; n++) random_frame();

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // absolute time guard
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
